// File: rtl/e203_sysper_icb_ram_pkg.sv
// Shared definitions for the sysper ICB scratch RAM: FSM encoding,
// counter width and latency bounds, plus a saturating-increment helper.
package e203_sysper_icb_ram_pkg;

    // Transaction FSM: accept a command, optionally wait, then present the response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    localparam int CNT_W       = 16;
    localparam int MAX_LATENCY = 4;
    // The latency counter only needs to hold LATENCY-2, i.e. up to MAX_LATENCY-2.
    localparam int LAT_W       = 2;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/e203_sysper_ram_array.sv
// DEPTH x 32 single-port-style RAM with one write and one registered read port.
// Byte enables on write. Kept as its own module so a technology macro can
// replace it without touching the ICB control logic.
module e203_sysper_ram_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wmask,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-masked write; storage is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read; output holds its value until the next read enable.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/e203_sysper_icb_ram.sv
// ICB slave terminating the sysper port with a word-addressed scratch RAM.
// One outstanding transaction at a time, response after LATENCY cycles,
// error response outside the BASE_ADDR window, saturating debug counters.
module e203_sysper_icb_ram
    import e203_sysper_icb_ram_pkg::*;
#(
    parameter int            AW        = 32,
    parameter int            DEPTH     = 256,
    parameter logic [AW-1:0] BASE_ADDR = 32'h1000_0000,
    parameter int            LATENCY   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             icb_cmd_valid,
    output logic             icb_cmd_ready,
    input  logic [AW-1:0]    icb_cmd_addr,
    input  logic             icb_cmd_read,
    input  logic [31:0]      icb_cmd_wdata,
    input  logic [3:0]       icb_cmd_wmask,
    output logic             icb_rsp_valid,
    input  logic             icb_rsp_ready,
    output logic             icb_rsp_err,
    output logic [31:0]      icb_rsp_rdata,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int IDX_W = $clog2(DEPTH);
    // Value loaded into the wait counter; WAIT is never entered when LATENCY==1.
    localparam logic [LAT_W-1:0] LAT_LOAD =
        (LATENCY >= 2) ? LAT_W'(LATENCY - 2) : '0;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] lat_cnt;
    logic             cmd_hs, rsp_hs;
    logic             in_win;
    logic [IDX_W-1:0] cmd_idx;
    logic             rd_q, err_q;
    logic [31:0]      ram_rdata;
    logic             ram_we, ram_re;
    logic             unused_addr;

    // Byte offset bits carry no meaning: accesses are always whole words.
    assign unused_addr = ^icb_cmd_addr[1:0];

    // Address decode: window match on the bits above the RAM span.
    assign in_win  = (icb_cmd_addr[AW-1:IDX_W+2] == BASE_ADDR[AW-1:IDX_W+2]);
    assign cmd_idx = icb_cmd_addr[IDX_W+1:2];

    assign cmd_hs = icb_cmd_valid & icb_cmd_ready;
    assign rsp_hs = icb_rsp_valid & icb_rsp_ready;

    // The RAM is both written and read at the command handshake, so the
    // word index never needs to be held past that cycle.
    assign ram_we = cmd_hs & ~icb_cmd_read & in_win;
    assign ram_re = cmd_hs &  icb_cmd_read & in_win;

    e203_sysper_ram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (cmd_idx),
        .wdata (icb_cmd_wdata),
        .wmask (icb_cmd_wmask),
        .re    (ram_re),
        .raddr (cmd_idx),
        .rdata (ram_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    state_d = (LATENCY == 1) ? ST_RSP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt == '0) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; response payload is forced to zero for writes and errors.
    always_comb begin
        icb_cmd_ready = (state_q == ST_IDLE) & ~rst;
        icb_rsp_valid = (state_q == ST_RSP)  & ~rst;
        icb_rsp_err   = icb_rsp_valid & err_q;
        icb_rsp_rdata = (icb_rsp_valid & rd_q & ~err_q) ? ram_rdata : 32'h0;
    end

    // Latency counter: loaded at the handshake, counts down while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (cmd_hs) begin
            lat_cnt <= LAT_LOAD;
        end else if ((state_q == ST_WAIT) && (lat_cnt != '0)) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
        end
    end

    // Response attributes captured at the command handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= 1'b0;
            err_q <= 1'b0;
        end else if (cmd_hs) begin
            rd_q  <= icb_cmd_read;
            err_q <= ~in_win;
        end
    end

    // Saturating debug counters: errors take precedence over read/write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else if (cmd_hs) begin
            if (!in_win) begin
                err_cnt <= sat_inc(err_cnt);
            end else if (icb_cmd_read) begin
                rd_cnt  <= sat_inc(rd_cnt);
            end else begin
                wr_cnt  <= sat_inc(wr_cnt);
            end
        end
    end

endmodule

// File: tb/tb_e203_sysper_icb_ram.sv
// Bench for e203_sysper_icb_ram: two instances (LATENCY 1 and 3) checked
// with a directed vector table, hand-written corner sequences and random
// traffic against a word-array reference model.
module tb_e203_sysper_icb_ram;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [31:0] cmd_addr  [2];
    logic        cmd_read  [2];
    logic [31:0] cmd_wdata [2];
    logic [3:0]  cmd_wmask [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic        rsp_err   [2];
    logic [31:0] rsp_rdata [2];
    logic [15:0] rd_cnt    [2];
    logic [15:0] wr_cnt    [2];
    logic [15:0] err_cnt   [2];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_mem   [2][DEPTH];
    bit          m_known [2][DEPTH];
    int          m_rd    [2];
    int          m_wr    [2];
    int          m_err   [2];

    e203_sysper_icb_ram #(.AW(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .icb_cmd_valid(cmd_valid[0]), .icb_cmd_ready(cmd_ready[0]),
        .icb_cmd_addr(cmd_addr[0]), .icb_cmd_read(cmd_read[0]),
        .icb_cmd_wdata(cmd_wdata[0]), .icb_cmd_wmask(cmd_wmask[0]),
        .icb_rsp_valid(rsp_valid[0]), .icb_rsp_ready(rsp_ready[0]),
        .icb_rsp_err(rsp_err[0]), .icb_rsp_rdata(rsp_rdata[0]),
        .rd_cnt(rd_cnt[0]), .wr_cnt(wr_cnt[0]), .err_cnt(err_cnt[0])
    );

    e203_sysper_icb_ram #(.AW(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .icb_cmd_valid(cmd_valid[1]), .icb_cmd_ready(cmd_ready[1]),
        .icb_cmd_addr(cmd_addr[1]), .icb_cmd_read(cmd_read[1]),
        .icb_cmd_wdata(cmd_wdata[1]), .icb_cmd_wmask(cmd_wmask[1]),
        .icb_rsp_valid(rsp_valid[1]), .icb_rsp_ready(rsp_ready[1]),
        .icb_rsp_err(rsp_err[1]), .icb_rsp_rdata(rsp_rdata[1]),
        .rd_cnt(rd_cnt[1]), .wr_cnt(wr_cnt[1]), .err_cnt(err_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: window is the DEPTH*4 bytes starting at BASE; low address bits ignored.
    function automatic bit mdl_inwin(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(DEPTH * 4);
    endfunction

    function automatic int mdl_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2);
    endfunction

    function automatic void mdl_apply(input int d, input logic [31:0] a, input logic rd,
                                      input logic [31:0] wd, input logic [3:0] wm);
        int w;
        if (!mdl_inwin(a)) begin
            m_err[d] = sat(m_err[d]);
        end else if (rd) begin
            m_rd[d] = sat(m_rd[d]);
        end else begin
            w = mdl_idx(a);
            for (int b = 0; b < 4; b++)
                if (wm[b]) m_mem[d][w][8*b +: 8] = wd[8*b +: 8];
            if (wm == 4'hF) m_known[d][w] = 1'b1;
            m_wr[d] = sat(m_wr[d]);
        end
    endfunction

    task automatic chk_cnts(input int d, input string tag);
        chk({tag, "_rd_cnt"},  {16'h0, rd_cnt[d]},  32'(m_rd[d]));
        chk({tag, "_wr_cnt"},  {16'h0, wr_cnt[d]},  32'(m_wr[d]));
        chk({tag, "_err_cnt"}, {16'h0, err_cnt[d]}, 32'(m_err[d]));
    endtask

    // One full transaction: issue command, measure latency, hold the
    // response for 'hold' cycles checking stability, then complete it.
    task automatic do_txn(input int d, input logic [31:0] a, input logic rd,
                          input logic [31:0] wd, input logic [3:0] wm, input int hold,
                          output logic [31:0] rdata_o, output logic err_o);
        int n;
        logic [31:0] r0;
        logic e0;
        rdata_o = 32'h0;
        err_o   = 1'b0;
        @(posedge clk); #1;
        cmd_valid[d] = 1'b1; cmd_addr[d] = a; cmd_read[d] = rd;
        cmd_wdata[d] = wd;   cmd_wmask[d] = wm; rsp_ready[d] = 1'b0;
        @(negedge clk);
        n = 0;
        while (!cmd_ready[d] && n < 20) begin @(negedge clk); n++; end
        if (!cmd_ready[d]) begin
            chk("cmd_accept_timeout", 32'(cmd_ready[d]), 32'h1);
            @(posedge clk); #1; cmd_valid[d] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid[d] = 1'b0;
        mdl_apply(d, a, rd, wd, wm);
        n = 1;
        @(negedge clk);
        while (!rsp_valid[d] && n < 10) begin
            chk("cmd_ready_while_wait", 32'(cmd_ready[d]), 32'h0);
            @(negedge clk); n++;
        end
        chk("latency", 32'(n), 32'(lat_of(d)));
        r0 = rsp_rdata[d];
        e0 = rsp_err[d];
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid",     32'(rsp_valid[d]), 32'h1);
            chk("hold_rdata",     rsp_rdata[d],      r0);
            chk("hold_err",       32'(rsp_err[d]),   32'(e0));
            chk("hold_cmd_ready", 32'(cmd_ready[d]), 32'h0);
        end
        @(posedge clk); #1; rsp_ready[d] = 1'b1;
        @(posedge clk); #1; rsp_ready[d] = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rsp", 32'(cmd_ready[d]), 32'h1);
        chk("rsp_valid_after_rsp", 32'(rsp_valid[d]), 32'h0);
        rdata_o = r0;
        err_o   = e0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] rdv;
        logic        erv;
        int          hs;

        tbl[0]  = '{32'h1000_0004, 1'b0, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0};
        tbl[1]  = '{32'h1000_0004, 1'b1, 32'h0,         4'h0, 1, 1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{32'h1000_0004, 1'b0, 32'h1122_3344, 4'h5, 0, 1'b0, 32'h0};
        tbl[3]  = '{32'h1000_0006, 1'b1, 32'h0,         4'h0, 2, 1'b0, 32'hDE22_BE44};
        tbl[4]  = '{32'h2000_0000, 1'b1, 32'h0,         4'h0, 1, 1'b1, 32'h0};
        tbl[5]  = '{32'h2000_0004, 1'b0, 32'hFFFF_FFFF, 4'hF, 0, 1'b1, 32'h0};
        tbl[6]  = '{32'h1000_0004, 1'b0, 32'hCAFE_F00D, 4'h0, 0, 1'b0, 32'h0};
        tbl[7]  = '{32'h1000_0004, 1'b1, 32'h0,         4'h0, 0, 1'b0, 32'hDE22_BE44};
        tbl[8]  = '{32'h1000_03FC, 1'b0, 32'h1234_5678, 4'hF, 0, 1'b0, 32'h0};
        tbl[9]  = '{32'h1000_03FF, 1'b1, 32'h0,         4'h0, 0, 1'b0, 32'h1234_5678};
        tbl[10] = '{32'h1000_0400, 1'b1, 32'h0,         4'h0, 0, 1'b1, 32'h0};
        tbl[11] = '{32'h0FFF_FFFC, 1'b1, 32'h0,         4'h0, 0, 1'b1, 32'h0};

        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0; cmd_addr[d] = 32'h0; cmd_read[d] = 1'b0;
            cmd_wdata[d] = 32'h0; cmd_wmask[d] = 4'h0; rsp_ready[d] = 1'b0;
            m_rd[d] = 0; m_wr[d] = 0; m_err[d] = 0;
            for (int w = 0; w < DEPTH; w++) begin
                m_mem[d][w] = 32'h0; m_known[d][w] = 1'b0;
            end
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_cmd_ready", 32'(cmd_ready[d]), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'h0);
            chk("rst_rsp_err",   32'(rsp_err[d]),   32'h0);
            chk("rst_rdata",     rsp_rdata[d],      32'h0);
            chk_cnts(d, "rst");
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready0", 32'(cmd_ready[0]), 32'h1);
        chk("post_rst_cmd_ready1", 32'(cmd_ready[1]), 32'h1);

        // Directed vector table on the LATENCY=1 instance
        for (int i = 0; i < 12; i++) begin
            do_txn(0, tbl[i].addr, tbl[i].rd, tbl[i].wdata, tbl[i].wmask, tbl[i].hold, rdv, erv);
            chk($sformatf("tbl%0d_err", i),   32'(erv), 32'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_rdata", i), rdv,      tbl[i].exp_rdata);
        end
        chk("tbl_wr_cnt",  {16'h0, wr_cnt[0]},  32'd4);
        chk("tbl_rd_cnt",  {16'h0, rd_cnt[0]},  32'd4);
        chk("tbl_err_cnt", {16'h0, err_cnt[0]}, 32'd4);

        // LATENCY=3 with a stalled response
        do_txn(1, 32'h1000_0020, 1'b0, 32'h0BAD_F00D, 4'hF, 5, rdv, erv);
        chk("lat3_wr_rdata", rdv, 32'h0);
        do_txn(1, 32'h1000_0020, 1'b1, 32'h0, 4'h0, 5, rdv, erv);
        chk("lat3_rd_rdata", rdv, 32'h0BAD_F00D);
        chk("lat3_rd_err",   32'(erv), 32'h0);
        chk_cnts(1, "lat3");

        // Reset while the LATENCY=3 instance is waiting after a write
        @(posedge clk); #1;
        cmd_valid[1] = 1'b1; cmd_addr[1] = 32'h1000_0010; cmd_read[1] = 1'b0;
        cmd_wdata[1] = 32'hA5A5_A5A5; cmd_wmask[1] = 4'hF;
        @(negedge clk);
        chk("rstwait_accept", 32'(cmd_ready[1]), 32'h1);
        @(posedge clk); #1; cmd_valid[1] = 1'b0;
        mdl_apply(1, 32'h1000_0010, 1'b0, 32'hA5A5_A5A5, 4'hF);
        @(negedge clk);
        chk("rstwait_in_wait", 32'(rsp_valid[1]), 32'h0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstwait_rsp_valid", 32'(rsp_valid[1]), 32'h0);
            chk("rstwait_cmd_ready", 32'(cmd_ready[1]), 32'h0);
        end
        @(posedge clk); #1; rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_rd[d] = 0; m_wr[d] = 0; m_err[d] = 0;
        end
        @(negedge clk);
        chk("rstwait_rsp_valid_after", 32'(rsp_valid[1]), 32'h0);
        chk("rstwait_cmd_ready_after", 32'(cmd_ready[1]), 32'h1);
        chk_cnts(0, "rstwait0");
        chk_cnts(1, "rstwait1");
        do_txn(1, 32'h1000_0010, 1'b1, 32'h0, 4'h0, 0, rdv, erv);
        chk("rstwait_readback", rdv, 32'hA5A5_A5A5);

        // Random traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            int          d;
            logic [31:0] a;
            logic        rd;
            logic [31:0] wd;
            logic [3:0]  wm;
            logic [31:0] exp_rd;
            logic        exp_err;
            bit          known;
            d  = int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = BASE + {$urandom_range(0, 15), 2'b00} + 32'($urandom_range(0, 3));
            rd = 1'($urandom_range(0, 1));
            wd = $urandom;
            wm = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) wm = 4'hF;
            exp_err = !mdl_inwin(a);
            exp_rd  = 32'h0;
            known   = 1'b1;
            if (!exp_err && rd) begin
                exp_rd = m_mem[d][mdl_idx(a)];
                known  = m_known[d][mdl_idx(a)];
            end
            do_txn(d, a, rd, wd, wm, int'($urandom_range(0, 3)), rdv, erv);
            chk("rand_err", 32'(erv), 32'(exp_err));
            if (known) chk("rand_rdata", rdv, exp_rd);
            chk_cnts(d, "rand");
        end

        // Counter saturation: preload rd_cnt near the top, then stream reads
        @(negedge clk);
        force u_dut0.rd_cnt = 16'hFFFB;
        @(negedge clk);
        release u_dut0.rd_cnt;
        m_rd[0] = 65531;
        @(negedge clk);
        chk("sat_preload", {16'h0, rd_cnt[0]}, 32'h0000_FFFB);
        @(posedge clk); #1;
        cmd_valid[0] = 1'b1; cmd_addr[0] = 32'h1000_0004; cmd_read[0] = 1'b1;
        cmd_wmask[0] = 4'h0; rsp_ready[0] = 1'b1;
        hs = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (cmd_valid[0] && cmd_ready[0]) hs++;
        end
        @(posedge clk); #1; cmd_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1; rsp_ready[0] = 1'b0;
        for (int k = 0; k < hs; k++) m_rd[0] = sat(m_rd[0]);
        @(negedge clk);
        chk("stream_throughput", 32'(hs), 32'd6);
        chk("sat_rd_cnt", {16'h0, rd_cnt[0]}, 32'h0000_FFFF);
        chk_cnts(0, "sat");
        chk("sat_idle", 32'(cmd_ready[0]), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
